// File: rtl/tff_count_sequencer.sv
// Toggle-vector sequencer for a bank of T flip-flops: turns the bank's fed-back
// state into per-bit toggle enables that count up/down, load, reload or clear it.
module tff_count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             dir,
  input  logic             wrap,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] t_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t cur;
  logic   at_top;
  logic   at_zero;
  logic   counting;

  assign at_top   = (q_in == limit);
  assign at_zero  = (q_in == '0);
  assign counting = (cur == RUN) && !stop && !load && !pause;

  // Toggle vector: bit i flips when (next value XOR current value) has bit i set.
  // Gated by rst so the bank sees no toggles while reset is held.
  always_comb begin
    t_out = '0;
    if (!rst && !stop) begin
      if (load) begin
        t_out = q_in ^ load_val;
      end else if (counting) begin
        if (dir) begin
          if (!at_top)   t_out = q_in ^ (q_in + ONE);
          else if (wrap) t_out = q_in;
        end else begin
          if (!at_zero)  t_out = q_in ^ (q_in - ONE);
          else if (wrap) t_out = limit;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= IDLE;
    end else if (stop) begin
      cur <= IDLE;
    end else begin
      case (cur)
        IDLE: if (start) cur <= RUN;
        RUN: begin
          if (!load) begin
            if (pause)
              cur <= HOLD;
            else if (dir && at_top && !wrap)
              cur <= DONE;
            else if (!dir && at_zero && !wrap)
              cur <= DONE;
          end
        end
        HOLD: if (!load && !pause) cur <= RUN;
        // DONE lasts exactly one cycle regardless of load.
        DONE: cur <= IDLE;
        default: cur <= IDLE;
      endcase
    end
  end

  assign state = cur;
  assign busy  = (cur == RUN) || (cur == HOLD);
  assign done  = (cur == DONE);

endmodule
